// File: rtl/batcharger_sar_seq.sv
// rtl/batcharger_sar_seq.sv - SAR sequencer for the charger V/I/T measurement ADC
// Walks the latched channel mask through SAMPLE, CONV and STORE, then pulses vtok.
module batcharger_sar_seq #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vmeasen,
  input  logic             imeasen,
  input  logic             tmeasen,
  input  logic             cmp,
  output logic [1:0]       chsel,
  output logic             sample,
  output logic [NBITS-1:0] dac,
  output logic [NBITS-1:0] vbat,
  output logic [NBITS-1:0] ibat,
  output logic [NBITS-1:0] tbat,
  output logic             vtok
);

  localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONV,
    S_STORE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       mask_q, mask_d;
  logic [1:0]       chan_q, chan_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [NBITS-1:0] code_q, code_d;
  logic [NBITS-1:0] vbat_q, vbat_d;
  logic [NBITS-1:0] ibat_q, ibat_d;
  logic [NBITS-1:0] tbat_q, tbat_d;
  logic             vtok_q, vtok_d;

  logic [2:0]       req;
  logic [NBITS-1:0] trial;

  // Mask bit 0 = V, 1 = I, 2 = T; chsel encodes them as 1, 2, 3.
  function automatic logic [1:0] first_ch(input logic [2:0] m);
    if (m[0])      first_ch = 2'd1;
    else if (m[1]) first_ch = 2'd2;
    else if (m[2]) first_ch = 2'd3;
    else           first_ch = 2'd0;
  endfunction

  function automatic logic [2:0] drop_ch(input logic [2:0] m, input logic [1:0] ch);
    case (ch)
      2'd1:    drop_ch = m & 3'b110;
      2'd2:    drop_ch = m & 3'b101;
      2'd3:    drop_ch = m & 3'b011;
      default: drop_ch = m;
    endcase
  endfunction

  assign req   = {tmeasen, imeasen, vmeasen};
  assign trial = code_q | (NBITS'(1) << k_q);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    code_d  = code_q;
    vbat_d  = vbat_q;
    ibat_d  = ibat_q;
    tbat_d  = tbat_q;
    vtok_d  = 1'b0;
    chsel   = 2'b00;
    sample  = 1'b0;
    dac     = '0;

    case (state_q)
      S_IDLE: begin
        if (en && (req != 3'b000)) begin
          state_d = S_SAMPLE;
          chan_d  = first_ch(req);
          mask_d  = drop_ch(req, first_ch(req));
          cnt_d   = '0;
          code_d  = '0;
        end
      end

      S_SAMPLE: begin
        chsel  = chan_q;
        sample = 1'b1;
        if (!en) begin
          state_d = S_IDLE;
          mask_d  = 3'b000;
          chan_d  = 2'd0;
        end else if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
          state_d = S_CONV;
          k_d     = KW'(NBITS - 1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CONV: begin
        chsel = chan_q;
        dac   = trial;
        if (!en) begin
          state_d = S_IDLE;
          mask_d  = 3'b000;
          chan_d  = 2'd0;
        end else begin
          if (cmp) code_d = trial;
          if (k_q == '0) state_d = S_STORE;
          else           k_d = k_q - 1'b1;
        end
      end

      S_STORE: begin
        chsel = chan_q;
        dac   = code_q;
        if (!en) begin
          state_d = S_IDLE;
          mask_d  = 3'b000;
          chan_d  = 2'd0;
        end else begin
          case (chan_q)
            2'd1:    vbat_d = code_q;
            2'd2:    ibat_d = code_q;
            2'd3:    tbat_d = code_q;
            default: ;
          endcase
          // Remaining mask was latched at round start; live requests are ignored here.
          if (mask_q != 3'b000) begin
            state_d = S_SAMPLE;
            chan_d  = first_ch(mask_q);
            mask_d  = drop_ch(mask_q, first_ch(mask_q));
            cnt_d   = '0;
            code_d  = '0;
          end else begin
            state_d = S_IDLE;
            chan_d  = 2'd0;
            vtok_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        mask_d  = 3'b000;
        chan_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= 3'b000;
      chan_q  <= 2'd0;
      cnt_q   <= '0;
      k_q     <= '0;
      code_q  <= '0;
      vbat_q  <= '0;
      ibat_q  <= '0;
      tbat_q  <= '0;
      vtok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      code_q  <= code_d;
      vbat_q  <= vbat_d;
      ibat_q  <= ibat_d;
      tbat_q  <= tbat_d;
      vtok_q  <= vtok_d;
    end
  end

  assign vbat = vbat_q;
  assign ibat = ibat_q;
  assign tbat = tbat_q;
  assign vtok = vtok_q;

endmodule

// File: tb/tb_batcharger_sar_seq.sv
// tb/tb_batcharger_sar_seq.sv - scoreboard bench for batcharger_sar_seq
// Analog comparator model drives cmp; expected traces and results are queued at stimulus time.
module tb_batcharger_sar_seq;

  logic       clk = 1'b0;
  logic       rst, en, vmeasen, imeasen, tmeasen, cmp;
  logic [1:0] chsel;
  logic       sample, vtok;
  logic [7:0] dac, vbat, ibat, tbat;

  batcharger_sar_seq #(.NBITS(8), .SAMPLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .vmeasen(vmeasen), .imeasen(imeasen), .tmeasen(tmeasen),
    .cmp(cmp), .chsel(chsel), .sample(sample), .dac(dac),
    .vbat(vbat), .ibat(ibat), .tbat(tbat), .vtok(vtok)
  );

  always #5 clk = ~clk;

  // Analog side: per-channel input codes indexed by chsel; mode 1/2 = comparator stuck 1/0.
  logic [7:0] vin [0:3];
  int         mode;

  always_comb begin
    if (mode == 1)      cmp = 1'b1;
    else if (mode == 2) cmp = 1'b0;
    else                cmp = (vin[chsel] >= dac);
  end

  int errors = 0;
  int checks = 0;

  logic [10:0] trace_q [$];
  logic [23:0] res_q [$];
  logic [7:0]  mv, mi, mt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && chsel != 2'b00) begin
      if (trace_q.size() == 0) check("trace_unexpected", 32'({chsel, sample, dac}), 32'h0);
      else check("trace", 32'({chsel, sample, dac}), 32'(trace_q.pop_front()));
    end
    if (vtok) begin
      if (res_q.size() == 0) check("vtok_unexpected", 32'(vtok), 32'h0);
      else check("results", 32'({vbat, ibat, tbat}), 32'(res_q.pop_front()));
    end
  end

  function automatic logic model_cmp(input logic [1:0] ch, input logic [7:0] level);
    if (mode == 1)      return 1'b1;
    else if (mode == 2) return 1'b0;
    else                return vin[ch] >= level;
  endfunction

  function automatic logic [7:0] model_result(input logic [1:0] ch);
    if (mode == 1)      return 8'hFF;
    else if (mode == 2) return 8'h00;
    else                return vin[ch];
  endfunction

  // Expected per-cycle {chsel, sample, dac} for one channel, truncated to 'limit' cycles.
  task automatic push_trace(input logic [1:0] ch, input int limit, output int pushed);
    logic [7:0] code, t;
    pushed = 0;
    for (int s = 0; s < 2; s++)
      if (pushed < limit) begin trace_q.push_back({ch, 1'b1, 8'h00}); pushed++; end
    code = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      t = code + (8'd1 << b);
      if (pushed < limit) begin trace_q.push_back({ch, 1'b0, t}); pushed++; end
      if (model_cmp(ch, t)) code = t;
    end
    if (pushed < limit) begin trace_q.push_back({ch, 1'b0, code}); pushed++; end
  endtask

  task automatic set_req(input logic [2:0] m);
    vmeasen = m[0];
    imeasen = m[1];
    tmeasen = m[2];
  endtask

  // Called at a negedge; the request is seen on the next posedge (cycle 1).
  task automatic run_round(input logic [2:0] m, input int hold, input logic [2:0] late,
                           input int abort_at, input bit use_rst);
    int n, left, p;
    n    = 0;
    left = (abort_at > 0) ? abort_at : 1000;
    for (int c = 1; c <= 3; c++) begin
      if (m[c-1]) begin
        n++;
        push_trace(2'(c), left, p);
        left -= p;
        if (abort_at == 0) begin
          if (c == 1) mv = model_result(2'(c));
          if (c == 2) mi = model_result(2'(c));
          if (c == 3) mt = model_result(2'(c));
        end
      end
    end
    if (abort_at == 0) res_q.push_back({mv, mi, mt});
    set_req(m);
    for (int cyc = 1; cyc <= 11 * n + 20; cyc++) begin
      @(negedge clk);
      if (cyc == hold) set_req(late);
      if (abort_at > 0 && cyc == abort_at) begin
        if (use_rst) begin #2 rst = 1'b1; end
        else en = 1'b0;
        return;
      end
      if (abort_at == 0 && vtok) begin
        check("round_latency", 32'(cyc), 32'(11 * n + 1));
        return;
      end
    end
    check("round_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 0;
    set_req(3'b000);
    for (int c = 0; c < 4; c++) vin[c] = 8'h00;
    mv = 8'h00; mi = 8'h00; mt = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_chsel", 32'(chsel), 32'h0);
    check("reset_sample_dac", 32'({sample, dac}), 32'h0);
    check("reset_results", 32'({vbat, ibat, tbat}), 32'h0);
    check("reset_vtok", 32'(vtok), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    vin[1] = 8'h99;
    run_round(3'b001, 1, 3'b000, 0, 1'b0);

    vin[1] = 8'hD6; vin[2] = 8'h19; vin[3] = 8'h3D;
    run_round(3'b111, 1, 3'b000, 0, 1'b0);

    mode = 1; run_round(3'b010, 1, 3'b000, 0, 1'b0);
    mode = 2; run_round(3'b010, 1, 3'b000, 0, 1'b0);
    mode = 0;

    vin[3] = 8'h42;
    run_round(3'b100, 1, 3'b000, 0, 1'b0);
    vin[3] = 8'h77;
    run_round(3'b100, 1, 3'b000, 6, 1'b0);
    @(negedge clk);
    check("abort_idle_chsel", 32'(chsel), 32'h0);
    check("abort_idle_dac", 32'({sample, dac}), 32'h0);
    check("abort_tbat_kept", 32'(tbat), 32'h42);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_vtok", 32'(vtok), 32'h0);
      @(negedge clk);
    end
    en = 1'b1;

    vin[1] = 8'h5A; vin[3] = 8'hA5;
    run_round(3'b001, 4, 3'b100, 0, 1'b0);
    run_round(3'b100, 1, 3'b000, 0, 1'b0);

    vin[1] = 8'h33;
    run_round(3'b001, 6, 3'b000, 0, 1'b0);

    vin[1] = 8'hE7;
    run_round(3'b001, 1, 3'b000, 5, 1'b1);
    #1;
    check("rst_outputs", 32'({chsel, sample, dac, vtok}), 32'h0);
    check("rst_results", 32'({vbat, ibat, tbat}), 32'h0);
    mv = 8'h00; mi = 8'h00; mt = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vin[1] = 8'hC3;
    run_round(3'b001, 1, 3'b000, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int c = 1; c <= 3; c++) vin[c] = 8'($urandom_range(0, 255));
      run_round(3'($urandom_range(1, 7)), 1, 3'b000, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("trace_drained", 32'(trace_q.size()), 32'h0);
    check("results_drained", 32'(res_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
